// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder.
//   - State encodings for the IDLE / RUN / DONE controller.
//   - Default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE_ENC,
        ST_RUN  = RUN_ENC,
        ST_DONE = DONE_ENC
    } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// One-bit full adder built from two half-adder cells and an OR.
// Ports:
//   in1, in2 : operand bits
//   c_in     : carry in
//   sum      : in1 ^ in2 ^ c_in
//   c_out    : majority(in1, in2, c_in)
// -----------------------------------------------------------------------------
module full_adder_bit (
    input  logic in1,
    input  logic in2,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    // First half adder: operands only
    assign ha0_sum   = in1 ^ in2;
    assign ha0_carry = in1 & in2;

    // Second half adder: partial sum plus incoming carry
    assign sum       = ha0_sum ^ c_in;
    assign ha1_carry = ha0_sum & c_in;

    assign c_out     = ha0_carry | ha1_carry;

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial two's-complement adder. Operands are captured on a start
// handshake, then added LSB first, one bit per clock, through a single
// full-adder cell and a carry flip-flop. Results are registered and held
// until the next completed operation.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : request, sampled only in IDLE
//   a, b      : WIDTH-bit operands, captured on the accepting edge
//   c_in      : carry in, captured on the accepting edge
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse, result valid
//   sum       : (a + b + c_in) mod 2^WIDTH
//   c_out     : carry out of the MSB
//   overflow  : signed overflow (carry into MSB XOR carry out of MSB)
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Holds bits 0..WIDTH-2 of the result; the MSB is never stored here
    // because it is produced on the final edge straight into sum.
    logic [WIDTH-2:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    full_adder_bit u_fa (
        .in1   (a_q[0]),
        .in2   (b_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_carry)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // New bit enters at the MSB; on the final edge this is the full result.
    assign shifted  = {fa_sum, psum_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + 1'b1;
                psum_d  = shifted[WIDTH-1:1];
                if (last_bit) begin
                    // carry_q is the carry into the MSB at this point
                    sum_d   = shifted;
                    c_out_d = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule : serial_adder
